// File: rtl/spi_nibble_pkg.sv
// rtl/spi_nibble_pkg.sv - shared types and helpers for the SPI nibble receiver
//
// Purpose: FSM state encoding, acknowledge header constant and the frame
//          integrity check used by spi_nibble_rx.
// Ports:   none (package)

package spi_nibble_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      CHECK   = 2'd2,
      WAIT_CS = 2'd3
   } state_t;

   // Upper nibble of the byte returned on MISO during the following frame.
   localparam logic [3:0] ACK_HDR = 4'b0101;

   // A frame carries its payload twice: the high nibble is the inverse of the low one.
   function automatic logic frame_ok(input logic [7:0] frame);
      return frame[7:4] == ~frame[3:0];
   endfunction

endpackage

// File: rtl/spi_nibble_rx_if.sv
// rtl/spi_nibble_rx_if.sv - SPI bus bundle between master board and nibble receiver
//
// Purpose: groups the four SPI wires so the receiver and the bench share one bundle.
// Signals: sck  - SPI clock driven by the master
//          mosi - serial data, master to slave
//          cs_n - chip select, active low
//          miso - acknowledge data, slave to master
// Modports: master drives sck/mosi/cs_n and reads miso; slave is the reverse.

interface spi_nibble_rx_if;

   logic sck;
   logic mosi;
   logic cs_n;
   logic miso;

   modport master (
      output sck,
      output mosi,
      output cs_n,
      input  miso
   );

   modport slave (
      input  sck,
      input  mosi,
      input  cs_n,
      output miso
   );

endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with edge detection
//
// Purpose: brings an asynchronous pin into the clk domain and flags its edges.
// Ports:   clk   - system clock
//          rst   - synchronous active-high reset, loads RST_VAL into every flop
//          din   - asynchronous input
//          level - synchronized level (second flop)
//          rise  - one-cycle pulse on a synchronized 0->1 transition
//          fall  - one-cycle pulse on a synchronized 1->0 transition

module sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= RST_VAL;
         s2   <= RST_VAL;
         hist <= RST_VAL;
      end else begin
         s1   <= din;
         s2   <= s1;
         hist <= s2;
      end
   end

   assign level = s2;
   assign rise  = s2 & ~hist;
   assign fall  = ~s2 & hist;

endmodule

// File: rtl/spi_nibble_rx.sv
// rtl/spi_nibble_rx.sv - SPI mode-0 slave that receives checked 4-bit values
//
// Purpose: deserializes 8-bit MSB-first frames, accepts a frame only when its
//          high nibble is the inverse of its low nibble, holds the last
//          accepted nibble for the 7-segment decoder (nibble[3] -> A ...
//          nibble[0] -> D) and returns {ACK_HDR, nibble} on MISO during the
//          next frame.
// Ports:   clk       - system clock
//          rst       - synchronous active-high reset
//          spi       - SPI bundle (slave side): sck, mosi, cs_n in, miso out
//          nibble    - last accepted value, registered
//          valid     - one-cycle pulse in the cycle nibble takes a new value
//          frame_err - sticky error, set by short/timed-out/bad frames,
//                      cleared by the next accepted frame

module spi_nibble_rx
   import spi_nibble_pkg::*;
#(
   parameter int FRAME_BITS     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 rst,
   spi_nibble_rx_if.slave       spi,
   output logic [3:0]           nibble,
   output logic                 valid,
   output logic                 frame_err
);

   localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]   TO_MAX   = TW'(TIMEOUT_CYCLES);
   localparam logic [2:0]      LAST_BIT = 3'(FRAME_BITS - 1);

   // ---------------------------------------------------------------
   // Input synchronization
   // ---------------------------------------------------------------
   logic sck_lvl_unused;
   logic sck_rise;
   logic sck_fall;
   logic cs_lvl;
   logic cs_rise;
   logic cs_fall;
   logic mosi_s1;
   logic mosi_s2;

   sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (spi.sck),
      .level (sck_lvl_unused),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (spi.cs_n),
      .level (cs_lvl),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   // mosi only needs its level; same depth as sck so data and clock stay aligned.
   always_ff @(posedge clk) begin
      if (rst) begin
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         mosi_s1 <= spi.mosi;
         mosi_s2 <= mosi_s1;
      end
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   state_t                  state_q;
   state_t                  state_d;
   logic [FRAME_BITS-1:0]   shreg;
   logic [2:0]              bit_cnt;
   logic [TW-1:0]           idle_cnt;
   logic [7:0]              ack;

   logic last_edge;
   logic to_hit;

   assign last_edge = sck_rise && (bit_cnt == LAST_BIT);
   assign to_hit    = (idle_cnt == TO_MAX);

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cs_fall) state_d = SHIFT;
         end
         SHIFT: begin
            // The last data edge wins over a simultaneous deselect; the
            // deselect is then honoured from WAIT_CS.
            if (last_edge)              state_d = CHECK;
            else if (cs_rise || to_hit) state_d = IDLE;
         end
         CHECK: begin
            state_d = WAIT_CS;
         end
         WAIT_CS: begin
            if (cs_lvl) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: per-state actions
   // ---------------------------------------------------------------
   logic do_clear;
   logic do_shift;
   logic do_count;
   logic do_abort;
   logic do_accept;
   logic do_reject;
   logic do_ack_load;

   always_comb begin
      do_clear    = 1'b0;
      do_shift    = 1'b0;
      do_count    = 1'b0;
      do_abort    = 1'b0;
      do_accept   = 1'b0;
      do_reject   = 1'b0;
      do_ack_load = 1'b0;
      case (state_q)
         IDLE: begin
            do_clear    = 1'b1;
            do_ack_load = cs_fall;
         end
         SHIFT: begin
            do_shift = sck_rise;
            do_count = 1'b1;
            do_abort = !last_edge && (cs_rise || to_hit);
         end
         CHECK: begin
            do_accept = frame_ok(shreg);
            do_reject = !frame_ok(shreg);
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------
   // Shift register, bit count, idle timeout, outputs, ack register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg     <= '0;
         bit_cnt   <= '0;
         idle_cnt  <= '0;
         nibble    <= 4'h0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         ack       <= 8'h00;
      end else begin
         valid <= do_accept;

         // Clearing in IDLE also guarantees the idle counter starts from zero
         // on entry to SHIFT.
         if (do_clear) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
         end else if (do_shift) begin
            shreg    <= {shreg[FRAME_BITS-2:0], mosi_s2};
            bit_cnt  <= bit_cnt + 3'd1;
            idle_cnt <= '0;
         end else if (do_count && !to_hit) begin
            idle_cnt <= idle_cnt + TW'(1);
         end

         if (do_accept) begin
            nibble    <= shreg[3:0];
            frame_err <= 1'b0;
         end else if (do_reject || do_abort) begin
            frame_err <= 1'b1;
         end

         // The ack byte reports the value held at the start of this frame.
         if (do_ack_load) begin
            ack <= {ACK_HDR, nibble};
         end else if (sck_fall) begin
            ack <= {ack[6:0], 1'b0};
         end
      end
   end

   // MSB is presented as soon as the frame starts; quiet whenever deselected.
   assign spi.miso = (state_q != IDLE) && !cs_lvl && ack[7];

endmodule
